// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each access takes a GRANT cycle (memory enabled) followed by a DONE cycle (completion pulse).
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [3:0]            wstrb0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic [3:0]            wstrb1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic [3:0]            mem_we,
   output logic                  mem_en,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StGrant, StDone} state_e;

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [3:0]            strb_q, strb_d;
   logic                  winner;

   // On a tie the requester that did not own the last access wins.
   always_comb begin
      if (req0 && req1) begin
         winner = ~last_q;
      end else begin
         winner = req1;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      data_d  = data_q;
      strb_d  = strb_q;
      case (state_q)
         StIdle, StDone: begin
            if (req0 || req1) begin
               state_d = StGrant;
               owner_d = winner;
               last_d  = winner;
               addr_d  = winner ? addr1  : addr0;
               data_d  = winner ? wdata1 : wdata0;
               strb_d  = winner ? wstrb1 : wstrb0;
            end else begin
               state_d = StIdle;
            end
         end
         StGrant: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
      end
   end

   // Outputs decode from state so an asynchronous reset clears them immediately.
   assign mem_en   = (state_q == StGrant);
   assign mem_we   = mem_en ? strb_q : 4'h0;
   assign mem_addr = addr_q;
   assign mem_din  = data_q;
   assign gnt0     = mem_en && !owner_q;
   assign gnt1     = mem_en && owner_q;
   assign rvalid0  = (state_q == StDone) && !owner_q;
   assign rvalid1  = (state_q == StDone) && owner_q;
   assign rdata0   = rvalid0 ? mem_dout : '0;
   assign rdata1   = rvalid1 ? mem_dout : '0;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-writable memory model and a
// scoreboard of expected completions.
module tb_mem_port_arbiter;

   logic        sysclk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [12:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic [3:0]  wstrb0, wstrb1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;
   logic [12:0] mem_addr;
   logic [31:0] mem_din;
   logic [3:0]  mem_we;
   logic        mem_en;
   logic [31:0] mem_dout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          who;
      bit          rd;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   always #5 sysclk = ~sysclk;

   mem_port_arbiter dut (
      .sysclk  (sysclk),
      .rst     (rst),
      .req0    (req0),
      .addr0   (addr0),
      .wdata0  (wdata0),
      .wstrb0  (wstrb0),
      .gnt0    (gnt0),
      .rvalid0 (rvalid0),
      .rdata0  (rdata0),
      .req1    (req1),
      .addr1   (addr1),
      .wdata1  (wdata1),
      .wstrb1  (wstrb1),
      .gnt1    (gnt1),
      .rvalid1 (rvalid1),
      .rdata1  (rdata1),
      .mem_addr(mem_addr),
      .mem_din (mem_din),
      .mem_we  (mem_we),
      .mem_en  (mem_en),
      .mem_dout(mem_dout),
      .busy    (busy)
   );

   // Memory model: unwritten words hold a fixed pattern, word 0x010 holds 0xDEADBEEF.
   bit [31:0] mem     [0:8191];
   bit        written [0:8191];

   function automatic logic [31:0] init_word(input logic [12:0] a);
      return (a == 13'h010) ? 32'hDEADBEEF : ({19'h0, a} ^ 32'hA5A50000);
   endfunction

   always @(posedge sysclk) begin
      logic [31:0] w;
      if (mem_en) begin
         w = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
         mem_dout <= w;
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) w[8*b +: 8] = mem_din[8*b +: 8];
         end
         if (mem_we != 4'h0) begin
            mem[mem_addr]     <= w;
            written[mem_addr] <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_acc(input int who, input bit rd, input logic [31:0] d);
      exp_t e;
      e.who  = who;
      e.rd   = rd;
      e.data = d;
      sb.push_back(e);
   endtask

   // Advance one clock and score any completion against the queue.
   task automatic cycle();
      exp_t e;
      @(posedge sysclk);
      #1;
      if (!rvalid0) chk("rdata0_idle_zero", rdata0, 32'h0);
      if (!rvalid1) chk("rdata1_idle_zero", rdata1, 32'h0);
      if (rvalid0 || rvalid1) begin
         chk("rvalid_one_hot", {31'h0, rvalid0 && rvalid1}, 32'h0);
         chk("rvalid_expected", {31'h0, sb.size() != 0}, 32'h1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rvalid_owner", {31'h0, rvalid1}, e.who);
            if (e.rd) chk("rdata", rvalid1 ? rdata1 : rdata0, e.data);
         end
      end
   endtask

   task automatic wait_grant();
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!(gnt0 || gnt1) && n < 4);
      chk("grant_timeout", {31'h0, gnt0 || gnt1}, 32'h1);
   endtask

   initial begin
      rst = 1'b0;
      req0 = 1'b0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
      req1 = 1'b0; addr1 = '0; wdata1 = '0; wstrb1 = '0;
      cycle();
      cycle();
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
      chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
      chk("rst_gnt", {30'h0, gnt1, gnt0}, 32'h0);
      chk("rst_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
      chk("rst_mem_addr", {19'h0, mem_addr}, 32'h0);
      chk("rst_mem_din", mem_din, 32'h0);
      rst = 1'b1;
      cycle();

      // Single read by requester 0.
      req0 = 1'b1; addr0 = 13'h010; wstrb0 = 4'h0;
      expect_acc(0, 1'b1, 32'hDEADBEEF);
      cycle();
      chk("rd_gnt0", {30'h0, gnt1, gnt0}, 32'h1);
      chk("rd_mem_en", {31'h0, mem_en}, 32'h1);
      chk("rd_mem_we", {28'h0, mem_we}, 32'h0);
      chk("rd_mem_addr", {19'h0, mem_addr}, 32'h010);
      chk("rd_busy", {31'h0, busy}, 32'h1);
      req0 = 1'b0;
      cycle();
      chk("rd_rvalid0", {30'h0, rvalid1, rvalid0}, 32'h1);
      chk("rd_mem_en_done", {31'h0, mem_en}, 32'h0);
      cycle();
      chk("rd_back_idle", {31'h0, busy}, 32'h0);

      // Write by requester 1, then read it back through requester 0.
      req1 = 1'b1; addr1 = 13'h004; wdata1 = 32'h12345678; wstrb1 = 4'hF;
      expect_acc(1, 1'b0, 32'h0);
      cycle();
      chk("wr_gnt1", {30'h0, gnt1, gnt0}, 32'h2);
      chk("wr_mem_we", {28'h0, mem_we}, 32'hF);
      chk("wr_mem_addr", {19'h0, mem_addr}, 32'h004);
      chk("wr_mem_din", mem_din, 32'h12345678);
      req1 = 1'b0;
      cycle();
      chk("wr_rvalid1", {30'h0, rvalid1, rvalid0}, 32'h2);
      chk("wr_mem_we_done", {28'h0, mem_we}, 32'h0);
      cycle();
      req0 = 1'b1; addr0 = 13'h004; wstrb0 = 4'h0;
      expect_acc(0, 1'b1, 32'h12345678);
      cycle();
      chk("rb_gnt0", {30'h0, gnt1, gnt0}, 32'h1);
      req0 = 1'b0;
      cycle();
      cycle();

      // Tie immediately after reset: requester 0 first.
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      req0 = 1'b1; addr0 = 13'h010; wstrb0 = 4'h0;
      req1 = 1'b1; addr1 = 13'h004; wstrb1 = 4'h0;
      expect_acc(0, 1'b1, 32'hDEADBEEF);
      expect_acc(1, 1'b1, 32'h12345678);
      cycle();
      chk("tie_first_gnt0", {30'h0, gnt1, gnt0}, 32'h1);
      req0 = 1'b0;
      cycle();
      chk("tie_rvalid0", {30'h0, rvalid1, rvalid0}, 32'h1);
      cycle();
      chk("tie_second_gnt1", {30'h0, gnt1, gnt0}, 32'h2);
      req1 = 1'b0;
      cycle();
      chk("tie_rvalid1_at_4", {30'h0, rvalid1, rvalid0}, 32'h2);
      cycle();

      // Fairness under continuous contention; last owner was 1 so 0 leads.
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_grant();
         chk("fair_order", {30'h0, gnt1, gnt0}, (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("fair_addr", {19'h0, mem_addr}, (i % 2 == 0) ? 32'h010 : 32'h004);
         if (gnt1) expect_acc(1, 1'b1, 32'h12345678);
         else      expect_acc(0, 1'b1, 32'hDEADBEEF);
      end
      req0 = 1'b0; req1 = 1'b0;
      cycle();
      cycle();
      chk("fair_idle", {31'h0, busy}, 32'h0);

      // Reset during GRANT aborts the access.
      req0 = 1'b1; addr0 = 13'h010; wstrb0 = 4'h0;
      cycle();
      chk("abort_in_grant", {31'h0, mem_en}, 32'h1);
      rst = 1'b0;
      #1;
      chk("abort_mem_en", {31'h0, mem_en}, 32'h0);
      chk("abort_gnt", {30'h0, gnt1, gnt0}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      req0 = 1'b0;
      cycle();
      chk("abort_no_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
      cycle();
      rst = 1'b1;
      cycle();
      chk("abort_no_rvalid_after", {30'h0, rvalid1, rvalid0}, 32'h0);
      req1 = 1'b1; addr1 = 13'h004; wstrb1 = 4'h0;
      expect_acc(1, 1'b1, 32'h12345678);
      cycle();
      chk("resume_gnt1", {30'h0, gnt1, gnt0}, 32'h2);
      req1 = 1'b0;
      cycle();
      chk("resume_rvalid1", {30'h0, rvalid1, rvalid0}, 32'h2);
      cycle();

      // Idle window.
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("idle_busy", {31'h0, busy}, 32'h0);
         chk("idle_mem_en", {31'h0, mem_en}, 32'h0);
      end

      chk("scoreboard_empty", sb.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, word address width of the shared memory port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width of the shared memory port.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port sysclk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports reqN, input, 1, access request from requester N (N=0 CPU data side, N=1 loader/debug).
REQ-007 The block SHALL have ports addrN, input, ADDR_WIDTH, word address of requester N.
REQ-008 The block SHALL have ports wdataN, input, DATA_WIDTH, store data of requester N.
REQ-009 The block SHALL have ports wstrbN, input, 4, byte write enables of requester N; 0 means read.
REQ-010 The block SHALL have ports gntN, output, 1, one-cycle grant pulse to requester N.
REQ-011 The block SHALL have ports rvalidN, output, 1, one-cycle completion pulse to requester N.
REQ-012 The block SHALL have ports rdataN, output, DATA_WIDTH, read data to requester N, valid only while rvalidN=1.
REQ-013 The block SHALL have port mem_addr, output, ADDR_WIDTH, address to memory port.
REQ-014 The block SHALL have port mem_din, output, DATA_WIDTH, write data to memory port.
REQ-015 The block SHALL have port mem_we, output, 4, byte write enables to memory port.
REQ-016 The block SHALL have port mem_en, output, 1, memory port enable.
REQ-017 The block SHALL have port mem_dout, input, DATA_WIDTH, memory read data, valid one cycle after an enabled read.
REQ-018 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-019 The block SHALL implement FSM states IDLE, GRANT, DONE.
REQ-020 In IDLE or DONE, if any reqN=1, the block SHALL pick a winner, register its addr/wdata/wstrb into mem_addr/mem_din/mem_we, set owner, and enter GRANT next cycle.
REQ-021 If no request is pending, IDLE SHALL stay in IDLE and DONE SHALL return to IDLE.
REQ-022 In GRANT, the block SHALL drive mem_en=1 and gnt[owner]=1 for exactly that cycle, then enter DONE.
REQ-023 In DONE, the block SHALL drive rvalid[owner]=1 and rdata[owner]=mem_dout for exactly that cycle, for reads and for writes alike.
REQ-024 Outside GRANT, the block SHALL drive mem_en=0 and mem_we=0.
REQ-025 Latency from the cycle a request is sampled to gnt SHALL be 1 cycle, and to rvalid 2 cycles; back-to-back throughput SHALL be one access per 2 cycles.
REQ-026 Arbitration SHALL be round-robin on a last_owner bit: with only one req high, that requester wins; with both high, the requester not equal to last_owner wins.
REQ-027 last_owner SHALL update to owner on each entry to GRANT.
REQ-028 Requesters SHALL hold req/addr/wdata/wstrb stable until gnt and drop req the cycle after gnt unless issuing a new access; a request withdrawn before sampling SHALL be ignored.
REQ-029 rdataN SHALL be driven 0 when rvalidN=0.

Reset
REQ-030 While rst=0, asynchronously: state=IDLE, last_owner=1 (requester 0 wins the first tie), all gnt/rvalid/mem_en/mem_we/busy=0, and mem_addr/mem_din=0.
REQ-031 Reset asserted mid-access SHALL abort it with no gnt or rvalid pulse afterwards; operation SHALL resume from IDLE on the first rising edge after rst returns to 1.

Verification
REQ-032 The bench SHALL cover single read: req0=1, addr0=0x010, wstrb0=0, memory word 0x010 holds 0xDEADBEEF -> gnt0 at cycle+1, mem_en=1, mem_we=0; rvalid0 at cycle+2, rdata0=0xDEADBEEF.
REQ-033 The bench SHALL cover write: req1=1, addr1=0x004, wdata1=0x12345678, wstrb1=0xF -> in GRANT mem_we=0xF, mem_addr=0x004, mem_din=0x12345678; rvalid1 one cycle later; a subsequent read returns 0x12345678.
REQ-034 The bench SHALL cover a tie after reset: req0 and req1 high together -> requester 0 granted first, requester 1 granted in the next GRANT, rvalid1 four cycles after the first sample.
REQ-035 The bench SHALL cover fairness: req0 and req1 held high for 8 accesses -> grants strictly alternate 0,1,0,1,...
REQ-036 The bench SHALL cover reset mid-access: rst=0 during GRANT -> mem_en, gnt and busy drop immediately, no rvalid follows, and the next request after release is granted normally.
REQ-037 The bench SHALL cover idle: no requests for 10 cycles -> busy=0 and mem_en=0 throughout.
